read_scheduler: RTL and testbench

Arbitration controller for the four 3-bit-entry packet buffers fed by the button-driven packet entry logic. On a debounced, held read request, it scores each buffer from its current occupancy and picks the highest scorer. It then issues a one-cycle pop to that buffer and counts completed reads. It replaces ad-hoc read selection inside the entry logic with a clean sequenced handshake.

---
 rtl/read_scheduler_if.sv | 31 +++
 rtl/read_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_read_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/read_scheduler_if.sv
// +----------------------------------------------------------------------+
// | read_scheduler_if : request/occupancy/grant bundle for read_scheduler |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface read_scheduler_if;
   logic       swa;
   logic [2:0] occ1;
   logic [2:0] occ2;
   logic [2:0] occ3;
   logic [2:0] occ4;
   logic [3:0] pop;
   logic [1:0] grant_id;
   logic       grant_valid;
   logic       empty_hit;
   logic [4:0] read_count;
   logic       busy;

   modport master (
      output swa, occ1, occ2, occ3, occ4,
      input  pop, grant_id, grant_valid, empty_hit, read_count, busy
   );

   modport slave (
      input  swa, occ1, occ2, occ3, occ4,
      output pop, grant_id, grant_valid, empty_hit, read_count, busy
   );
endinterface

`default_nettype wire

// File: rtl/read_scheduler.sv
// +----------------------------------------------------------------------+
// | read_scheduler : held-switch triggered, occupancy-scored buffer pop   |
// | Optional macro READ_SCHED_AUTO_EN: repeat reads while swa stays high  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module read_scheduler #(
   parameter int TICK_CYCLES = 75000000,
   parameter int DEPTH       = 6
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   read_scheduler_if.slave   bus
);

   localparam logic [2:0]  S_IDLE     = 3'd0;
   localparam logic [2:0]  S_HOLD     = 3'd1;
   localparam logic [2:0]  S_SCORE    = 3'd2;
   localparam logic [2:0]  S_GRANT    = 3'd3;
   localparam logic [2:0]  S_SETTLE   = 3'd4;
   localparam logic [2:0]  S_WAIT_REL = 3'd5;

   localparam logic [26:0] C_LAST  = 27'(TICK_CYCLES - 1);
   localparam logic [2:0]  C_DEPTH = 3'(DEPTH);

   // Weighting favours B1 when lightly filled and B4 when heavily filled.
   function automatic logic [4:0] f_score(input logic [1:0] idx, input logic [2:0] occ);
      logic [4:0] n;
      logic [4:0] s;
      n = (occ > C_DEPTH) ? {2'b00, C_DEPTH} : {2'b00, occ};
      s = 5'd0;
      if (n != 5'd0) begin
         if (n <= 5'd3) begin
            case (idx)
               2'd0:    s = (n << 2) + 5'd1;
               2'd1:    s = (n << 1) + n + 5'd2;
               2'd2:    s = (n << 1) + 5'd3;
               default: s = n + 5'd4;
            endcase
         end else begin
            case (idx)
               2'd0:    s = n + 5'd4;
               2'd1:    s = (n << 1) + 5'd3;
               2'd2:    s = (n << 1) + n + 5'd2;
               default: s = (n << 2) + 5'd1;
            endcase
         end
      end
      return s;
   endfunction

   logic [2:0]  w_occ   [4];
   logic [4:0]  w_score [4];
   logic [4:0]  w_best;
   logic [1:0]  w_sel;
   logic        w_any;

   logic [2:0]  state_q, state_d;
   logic [26:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]  pop_q, pop_d;
   logic [1:0]  grant_id_q, grant_id_d;
   logic        grant_valid_q, grant_valid_d;
   logic        empty_hit_q, empty_hit_d;
   logic [4:0]  read_count_q, read_count_d;
   logic        busy_q, busy_d;

   always_comb begin
      w_occ[0] = bus.occ1;
      w_occ[1] = bus.occ2;
      w_occ[2] = bus.occ3;
      w_occ[3] = bus.occ4;
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_score
      assign w_score[gi] = f_score(2'(gi), w_occ[gi]);
   end

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      w_best = w_score[0];
      w_sel  = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (w_score[i] > w_best) begin
            w_best = w_score[i];
            w_sel  = 2'(i);
         end
      end
   end

   assign w_any = (w_best != 5'd0);

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      pop_d         = 4'b0000;
      grant_valid_d = 1'b0;
      empty_hit_d   = 1'b0;
      grant_id_d    = grant_id_q;
      read_count_d  = read_count_q;
      case (state_q)
         S_IDLE: begin
            hold_cnt_d = '0;
            if (bus.swa) begin
               hold_cnt_d = 27'd1;
               state_d    = (C_LAST == 27'd0) ? S_SCORE : S_HOLD;
            end
         end
         S_HOLD: begin
            if (!bus.swa) begin
               hold_cnt_d = '0;
               state_d    = S_IDLE;
            end else if (hold_cnt_q == C_LAST) begin
               hold_cnt_d = '0;
               state_d    = S_SCORE;
            end else begin
               hold_cnt_d = hold_cnt_q + 27'd1;
            end
         end
         // Outputs are registered here so the pulse is visible while in GRANT.
         S_SCORE: begin
            state_d = S_GRANT;
            if (w_any) begin
               pop_d         = 4'b0001 << w_sel;
               grant_valid_d = 1'b1;
               grant_id_d    = w_sel;
               read_count_d  = read_count_q + 5'd1;
            end else begin
               empty_hit_d = 1'b1;
            end
         end
         S_GRANT: state_d = S_SETTLE;
         S_SETTLE: begin
            if (!bus.swa) begin
               state_d = S_IDLE;
            end else begin
`ifdef READ_SCHED_AUTO_EN
               hold_cnt_d = 27'd1;
               state_d    = (C_LAST == 27'd0) ? S_SCORE : S_HOLD;
`else
               state_d = S_WAIT_REL;
`endif
            end
         end
         S_WAIT_REL: begin
            if (!bus.swa) state_d = S_IDLE;
         end
         default: begin
            state_d    = S_IDLE;
            hold_cnt_d = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         hold_cnt_q    <= '0;
         pop_q         <= 4'b0000;
         grant_id_q    <= 2'd0;
         grant_valid_q <= 1'b0;
         empty_hit_q   <= 1'b0;
         read_count_q  <= 5'd0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         pop_q         <= pop_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         empty_hit_q   <= empty_hit_d;
         read_count_q  <= read_count_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.pop         = pop_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.empty_hit   = empty_hit_q;
   assign bus.read_count  = read_count_q;
   assign bus.busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_read_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_read_scheduler : randomized + directed check of read_scheduler     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_read_scheduler;

   localparam int TICK  = 4;
   localparam int DEPTH = 6;

   logic clk;
   logic rst_n;
   read_scheduler_if bus ();

   read_scheduler #(.TICK_CYCLES(TICK), .DEPTH(DEPTH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_mis;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a timeline counted in clock edges since the trigger.
   int         m_run;
   int         m_after;
   bit         m_wait;
   logic [3:0] m_pop;
   logic [1:0] m_gid;
   logic       m_gv;
   logic       m_eh;
   int         m_cnt;

   int lo_mul [4] = '{4, 3, 2, 1};
   int lo_add [4] = '{1, 2, 3, 4};
   int hi_mul [4] = '{1, 2, 3, 4};
   int hi_add [4] = '{4, 3, 2, 1};

   function automatic int ref_score(input int b, input int occ);
      int n;
      n = (occ > DEPTH) ? DEPTH : occ;
      if (n == 0) return 0;
      if (n <= 3) return lo_mul[b] * n + lo_add[b];
      return hi_mul[b] * n + hi_add[b];
   endfunction

   task automatic m_reset();
      m_run = 0; m_after = 0; m_wait = 0;
      m_pop = 4'b0; m_gid = 2'd0; m_gv = 1'b0; m_eh = 1'b0; m_cnt = 0;
   endtask

   task automatic m_step();
      int occs [4];
      int best;
      int sel;
      occs[0] = int'(bus.occ1); occs[1] = int'(bus.occ2);
      occs[2] = int'(bus.occ3); occs[3] = int'(bus.occ4);
      m_pop = 4'b0; m_gv = 1'b0; m_eh = 1'b0;
      if (m_after == 1) begin
         best = 0; sel = 0;
         for (int b = 0; b < 4; b++) begin
            if (ref_score(b, occs[b]) > best) begin
               best = ref_score(b, occs[b]);
               sel  = b;
            end
         end
         if (best > 0) begin
            m_pop = 4'(1 << sel);
            m_gv  = 1'b1;
            m_gid = 2'(sel);
            m_cnt = (m_cnt + 1) % 32;
         end else begin
            m_eh = 1'b1;
         end
         m_after = 2;
      end else if (m_after == 2) begin
         m_after = 3;
      end else if (m_after == 3) begin
         m_after = 0;
         if (!bus.swa) m_run = 0;
         else begin
`ifdef READ_SCHED_AUTO_EN
            m_run = 1;
            if (m_run == TICK) begin m_after = 1; m_run = 0; end
`else
            m_wait = 1'b1;
`endif
         end
      end else if (m_wait) begin
         if (!bus.swa) begin m_wait = 1'b0; m_run = 0; end
      end else begin
         m_run = bus.swa ? m_run + 1 : 0;
         if (m_run == TICK) begin m_after = 1; m_run = 0; end
      end
   endtask

   always @(posedge clk) begin
      if (rst_n) begin
         m_step();
         #1;
         chk("pop",         32'(bus.pop),         32'(m_pop));
         chk("grant_valid", 32'(bus.grant_valid), 32'(m_gv));
         chk("empty_hit",   32'(bus.empty_hit),   32'(m_eh));
         chk("grant_id",    32'(bus.grant_id),    32'(m_gid));
         chk("read_count",  32'(bus.read_count),  32'(m_cnt));
         chk("busy",        32'(bus.busy),
             32'((m_after != 0) || m_wait || (m_run != 0)));
      end
   end

   task automatic set_occ(input int a, input int b, input int c, input int d);
      bus.occ1 = 3'(a); bus.occ2 = 3'(b); bus.occ3 = 3'(c); bus.occ4 = 3'(d);
   endtask

   task automatic hold_swa(input int hi);
      for (int i = 0; i < hi; i++) begin @(negedge clk); bus.swa = 1'b1; end
      for (int i = 0; i < 4; i++)  begin @(negedge clk); bus.swa = 1'b0; end
   endtask

   int run_left;
   int waited;

   initial begin
      n_cmp = 0; n_mis = 0;
      m_reset();
      rst_n = 1'b0;
      bus.swa = 1'b0;
      set_occ(0, 0, 0, 0);
      #12;
      chk("rst_pop",   32'(bus.pop),         32'd0);
      chk("rst_gv",    32'(bus.grant_valid), 32'd0);
      chk("rst_eh",    32'(bus.empty_hit),   32'd0);
      chk("rst_gid",   32'(bus.grant_id),    32'd0);
      chk("rst_count", 32'(bus.read_count),  32'd0);
      chk("rst_busy",  32'(bus.busy),        32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      set_occ(2, 0, 0, 0); hold_swa(6);
      chk("single_gid", 32'(bus.grant_id), 32'd0);
      chk("single_cnt", 32'(bus.read_count), 32'd1);
      set_occ(1, 1, 1, 1); hold_swa(5);
      chk("tie_gid", 32'(bus.grant_id), 32'd0);
      chk("tie_cnt", 32'(bus.read_count), 32'd2);
      set_occ(3, 0, 0, 5); hold_swa(5);
      chk("b4_gid", 32'(bus.grant_id), 32'd3);
      chk("b4_cnt", 32'(bus.read_count), 32'd3);
      set_occ(0, 0, 0, 0); hold_swa(5);
      chk("empty_cnt", 32'(bus.read_count), 32'd3);
      set_occ(7, 7, 7, 7); hold_swa(2);
      chk("short_cnt",  32'(bus.read_count), 32'd3);
      chk("short_busy", 32'(bus.busy), 32'd0);
      set_occ(0, 6, 0, 7); hold_swa(20);

      run_left = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (run_left == 0) begin
            bus.swa  = ~bus.swa;
            run_left = bus.swa ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 3));
         end
         run_left--;
         if ($urandom_range(0, 2) == 0)
            set_occ($urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
      end
      bus.swa = 1'b0;
      repeat (6) @(negedge clk);

      // Reset landing while the pop pulse is visible.
      set_occ(0, 4, 0, 0);
      bus.swa = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!m_gv && waited < 30);
      chk("grant_seen", 32'(m_gv), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_pop",   32'(bus.pop),         32'd0);
      chk("abort_gv",    32'(bus.grant_valid), 32'd0);
      chk("abort_count", 32'(bus.read_count),  32'd0);
      chk("abort_busy",  32'(bus.busy),        32'd0);
      m_reset();
      bus.swa = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_occ(2, 0, 0, 0); hold_swa(6);
      chk("recover_cnt", 32'(bus.read_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
